// File: rtl/dmem_pipe.sv
// Pipelined byte-addressable data memory with lane steering and load extension.
// Latency: READ_LAT cycles from accept to response; one request per cycle.
// Backpressure: rsp_valid && !rsp_ready freezes every stage and drops req_ready.
module dmem_pipe #(
    parameter int          DEPTH_BYTES = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_we
);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IW    = (AW > 2) ? AW - 2 : 1;
    localparam int WORDS = DEPTH_BYTES / 4;

    logic [31:0] mem [WORDS];

    logic        rst_done;
    logic        stall;
    logic        accept;
    logic [31:0] off;
    logic        in_range;
    logic        misal;
    logic        fault;
    logic [IW-1:0] widx;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] ldata;

    logic [READ_LAT-1:0] p_vld;
    logic [READ_LAT-1:0] p_we;
    logic [READ_LAT-1:0] p_err;
    logic [31:0]         p_dat [READ_LAT];

    assign off      = req_addr - BASE_ADDR;
    assign in_range = off < 32'(DEPTH_BYTES);
    assign widx     = off[IW+1:2];

    always_comb begin
        misal = 1'b0;
        case (req_size)
            2'd1:    misal = off[0];
            2'd2:    misal = (off[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
    end

    assign fault = (req_size == 2'd3) || !in_range || misal;

    // rst_done keeps req_ready low until the first edge after reset release.
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = rst_done && !stall;
    assign accept    = req_valid && req_ready;

    always_comb begin
        be   = 4'b1111;
        wrep = req_wdata;
        case (req_size)
            2'd0: begin
                be   = 4'b0001 << off[1:0];
                wrep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be   = off[1] ? 4'b1100 : 4'b0011;
                wrep = {2{req_wdata[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = req_wdata;
            end
        endcase
    end

    assign rword  = mem[widx];
    assign rshift = rword >> {off[1:0], 3'b000};

    always_comb begin
        ldata = 32'd0;
        if (!fault && !req_we) begin
            case (req_size)
                2'd0:    ldata = {{24{req_signed & rshift[7]}}, rshift[7:0]};
                2'd1:    ldata = {{16{req_signed & rshift[15]}}, rshift[15:0]};
                default: ldata = rword;
            endcase
        end
    end

    // Memory contents survive reset; accept already excludes reset via rst_done.
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done <= 1'b0;
            p_vld    <= '0;
            p_we     <= '0;
            p_err    <= '0;
            for (int i = 0; i < READ_LAT; i++) p_dat[i] <= 32'd0;
        end else begin
            rst_done <= 1'b1;
            if (!stall) begin
                p_vld[0] <= accept;
                p_we[0]  <= accept && req_we;
                p_err[0] <= accept && fault;
                p_dat[0] <= accept ? ldata : 32'd0;
                for (int i = 1; i < READ_LAT; i++) begin
                    p_vld[i] <= p_vld[i-1];
                    p_we[i]  <= p_we[i-1];
                    p_err[i] <= p_err[i-1];
                    p_dat[i] <= p_dat[i-1];
                end
            end
        end
    end

    assign rsp_valid = p_vld[READ_LAT-1];
    assign rsp_we    = p_we[READ_LAT-1];
    assign rsp_err   = p_err[READ_LAT-1];
    assign rsp_rdata = p_dat[READ_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: directed requests push expected responses,
// a monitor pops and compares each response the DUT hands over.
module tb_dmem_pipe;
    localparam int          LAT = 2;
    localparam int          D   = 2048;
    localparam logic [31:0] B   = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_we;

    dmem_pipe #(
        .DEPTH_BYTES(D),
        .BASE_ADDR  (B),
        .READ_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_we    (rsp_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] dat;
        int          cyc;
        bit          chk;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input bit lchk);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout addr=%h actual req_ready=0 required=1", a);
            req_valid = 1'b0;
            return;
        end
        e.we  = we;
        e.err = ee;
        e.dat = ed;
        e.cyc = cyc + LAT;
        e.chk = lchk;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout actual pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pops one expectation per handshake, checks hold stability under stall.
    initial begin
        exp_t        e;
        bit          hold_v;
        logic [33:0] held;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid && hold_v) begin
                n_cmp++;
                if ({rsp_we, rsp_err, rsp_rdata} !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold actual=%h required=%h", {rsp_we, rsp_err, rsp_rdata}, held);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp actual rdata=%h err=%b required no response", rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (rsp_we !== e.we || rsp_err !== e.err || rsp_rdata !== e.dat) begin
                        n_bad++;
                        $display("FAIL rsp actual we=%b err=%b rdata=%h required we=%b err=%b rdata=%h",
                                 rsp_we, rsp_err, rsp_rdata, e.we, e.err, e.dat);
                    end
                    if (e.chk) begin
                        n_cmp++;
                        if (cyc != e.cyc) begin
                            n_bad++;
                            $display("FAIL latency actual cycle=%0d required=%0d", cyc, e.cyc);
                        end
                    end
                end
            end
            if (rsp_valid && !rsp_ready) begin
                hold_v = 1'b1;
                held   = {rsp_we, rsp_err, rsp_rdata};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_fields", {rsp_we, rsp_err, rsp_rdata[29:0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);

        // word store then back-to-back load
        issue(1, 2'd2, 0, B,        32'hDEAD_BEEF, 32'h0,         0, 1);
        issue(0, 2'd2, 0, B,        32'h0,         32'hDEAD_BEEF, 0, 1);
        drain();

        // byte lane and extension
        issue(1, 2'd0, 0, B + 2,    32'h0000_0080, 32'h0,         0, 1);
        issue(0, 2'd0, 1, B + 2,    32'h0,         32'hFFFF_FF80, 0, 1);
        issue(0, 2'd0, 0, B + 2,    32'h0,         32'h0000_0080, 0, 1);
        issue(0, 2'd2, 0, B,        32'h0,         32'hDE80_BEEF, 0, 1);
        drain();

        // half lanes, misaligned half load and store
        issue(1, 2'd2, 0, B + 4,    32'h0,         32'h0,         0, 1);
        issue(1, 2'd1, 0, B + 6,    32'h0000_8001, 32'h0,         0, 1);
        issue(0, 2'd1, 1, B + 6,    32'h0,         32'hFFFF_8001, 0, 1);
        issue(0, 2'd1, 0, B + 6,    32'h0,         32'h0000_8001, 0, 1);
        issue(0, 2'd1, 1, B + 5,    32'h0,         32'h0,         1, 1);
        issue(1, 2'd1, 0, B + 5,    32'h0000_FFFF, 32'h0,         1, 1);
        issue(0, 2'd2, 0, B + 4,    32'h0,         32'h8001_0000, 0, 1);
        drain();

        // range, wrap, top of memory, illegal size
        issue(1, 2'd2, 0, B + D,       32'h1234_5678, 32'h0,         1, 1);
        issue(0, 2'd2, 0, 32'h1000_FFFC, 32'h0,       32'h0,         1, 1);
        issue(0, 2'd2, 0, B,           32'h0,         32'hDE80_BEEF, 0, 1);
        issue(1, 2'd2, 0, B + D - 4,   32'hCAFE_F00D, 32'h0,         0, 1);
        issue(0, 2'd2, 0, B + D - 4,   32'h0,         32'hCAFE_F00D, 0, 1);
        issue(0, 2'd1, 0, B + D - 1,   32'h0,         32'h0,         1, 1);
        issue(0, 2'd3, 0, B,           32'h0,         32'h0,         1, 1);
        issue(1, 2'd3, 0, B,           32'hFFFF_FFFF, 32'h0,         1, 1);
        issue(0, 2'd2, 0, B,           32'h0,         32'hDE80_BEEF, 0, 1);
        drain();

        // six loads with a three-cycle response stall mid-stream
        for (int i = 0; i < 6; i++)
            issue(1, 2'd2, 0, B + 32'h10 + 4*i, 32'hA000_0000 + i, 32'h0, 0, 1);
        drain();
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(0, 2'd2, 0, B + 32'h10 + 4*i, 32'h0, 32'hA000_0000 + i, 0, 0);
            end
            begin
                repeat (3) @(negedge clk);
                rsp_ready = 1'b0;
                #1;
                chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
                repeat (3) @(negedge clk);
                rsp_ready = 1'b1;
            end
        join
        drain();

        // reset mid-flight; the store presented during reset must not land
        issue(1, 2'd2, 0, B + 32'h40, 32'h1111_1111, 32'h0, 0, 1);
        drain();
        issue(0, 2'd2, 0, B,          32'h0,         32'hDE80_BEEF, 0, 1);
        issue(0, 2'd2, 0, B + 32'h10, 32'h0,         32'hA000_0000, 0, 1);
        issue(1, 2'd2, 0, B + 32'h44, 32'h55AA_55AA, 32'h0,         0, 1);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = B + 32'h40;
        req_wdata = 32'h2222_2222;
        exp_q.delete();
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        issue(0, 2'd2, 0, B + 32'h44, 32'h0, 32'h55AA_55AA, 0, 1);
        issue(0, 2'd2, 0, B + 32'h40, 32'h0, 32'h1111_1111, 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
